// File: rtl/imem_loader_pkg.sv
// Shared types and frame constants for the instruction-memory loader.
// Holds the loader FSM encoding and the helpers that classify its states.
package imem_loader_pkg;

  localparam int unsigned LEN_BYTES = 4;
  localparam int unsigned BYTE_W    = 8;
  localparam int unsigned WORD_W    = 32;
  localparam int unsigned IDX_W     = 2;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LEN  = 3'd1,
    DATA = 3'd2,
    CSUM = 3'd3,
    DONE = 3'd4,
    ERR  = 3'd5
  } loader_state_t;

  // States in which the byte stream is open.
  function automatic logic accepts_bytes(input loader_state_t s);
    return (s == LEN) || (s == DATA) || (s == CSUM);
  endfunction

  // States in which a start pulse opens a new session.
  function automatic logic can_start(input loader_state_t s);
    return (s == IDLE) || (s == DONE) || (s == ERR);
  endfunction

endpackage

// File: rtl/imem_loader_if.sv
// Byte-stream input and instruction-memory port-B write bus of the loader.
interface imem_loader_if #(
  parameter int unsigned ADDR_W = 12
);
  logic              s_valid;
  logic [7:0]        s_data;
  logic              s_ready;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;

  // Producer of bytes and consumer of memory writes.
  modport master (
    output s_valid, s_data,
    input  s_ready, mem_we, mem_addr, mem_wdata
  );

  // The loader itself.
  modport slave (
    input  s_valid, s_data,
    output s_ready, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/imem_byte_packer.sv
// Assembles accepted bytes into little-endian 32-bit words.
// word_c shows the word with the incoming byte merged; word_ready_c marks its 4th byte.
module imem_byte_packer
  import imem_loader_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              byte_en,
  input  logic [BYTE_W-1:0] byte_in,
  output logic [WORD_W-1:0] word_c,
  output logic              word_ready_c
);

  logic [IDX_W-1:0]  idx_q;
  logic [WORD_W-1:0] shreg_q;

  // Byte k of a word lands in bits [8k+7:8k].
  always_comb begin
    word_c = shreg_q;
    word_c[{idx_q, 3'b000} +: BYTE_W] = byte_in;
    word_ready_c = byte_en && (idx_q == IDX_W'(LEN_BYTES - 1));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q   <= '0;
      shreg_q <= '0;
    end else if (clr) begin
      idx_q   <= '0;
      shreg_q <= '0;
    end else if (byte_en) begin
      idx_q   <= idx_q + IDX_W'(1);
      shreg_q <= word_c;
    end
  end

endmodule

// File: rtl/imem_loader.sv
// Loads a length-prefixed, XOR-checksummed byte image into instruction memory
// through port B and keeps the core held until a verified image is in place.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int unsigned ADDR_W        = 12,
  parameter bit          HOLD_AT_RESET = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  imem_loader_if.slave      bus,
  output logic              core_hold,
  output logic              load_done,
  output logic              load_err,
  output logic [ADDR_W:0]   words_loaded
);

  localparam int unsigned       CNT_W     = ADDR_W + 1;
  localparam logic [WORD_W-1:0] MAX_WORDS = WORD_W'(1) << ADDR_W;

  loader_state_t state_q, state_d;

  logic              s_ready_q, s_ready_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [WORD_W-1:0] mem_wdata_q, mem_wdata_d;
  logic              core_hold_d, load_done_d, load_err_d;
  logic [CNT_W-1:0]  words_d;
  logic [CNT_W-1:0]  len_q, len_d;
  logic [BYTE_W-1:0] csum_q, csum_d;

  logic              accept_c;
  logic              start_c;
  logic              pk_en_c;
  logic              pk_clr_c;
  logic [WORD_W-1:0] pk_word_c;
  logic              pk_ready_c;
  logic              last_word_c;

  assign accept_c    = bus.s_valid && s_ready_q;
  assign start_c     = start && can_start(state_q);
  assign pk_en_c     = accept_c && ((state_q == LEN) || (state_q == DATA));
  assign pk_clr_c    = start_c;
  assign last_word_c = (words_loaded + CNT_W'(1)) == len_q;

  imem_byte_packer u_packer (
    .clk          (clk),
    .rst_n        (rst_n),
    .clr          (pk_clr_c),
    .byte_en      (pk_en_c),
    .byte_in      (bus.s_data),
    .word_c       (pk_word_c),
    .word_ready_c (pk_ready_c)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE, DONE, ERR: begin
        if (start) state_d = LEN;
      end
      LEN: begin
        if (pk_ready_c) begin
          if (pk_word_c > MAX_WORDS)      state_d = ERR;
          else if (pk_word_c == '0)       state_d = CSUM;
          else                            state_d = DATA;
        end
      end
      DATA: begin
        if (pk_ready_c && last_word_c) state_d = CSUM;
      end
      CSUM: begin
        if (accept_c) state_d = (bus.s_data == csum_q) ? DONE : ERR;
      end
      default: state_d = IDLE;
    endcase
  end

  // Next values of the registered outputs and datapath.
  always_comb begin
    s_ready_d   = accepts_bytes(state_d);
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    core_hold_d = core_hold;
    load_done_d = load_done;
    load_err_d  = load_err;
    words_d     = words_loaded;
    len_d       = len_q;
    csum_d      = csum_q;

    if (start_c) begin
      core_hold_d = 1'b1;
      load_done_d = 1'b0;
      load_err_d  = 1'b0;
      words_d     = '0;
      csum_d      = '0;
    end

    if ((state_q == LEN) && pk_ready_c) len_d = CNT_W'(pk_word_c);

    // A word leaves on the cycle after its 4th byte; the index advances with it.
    if ((state_q == DATA) && pk_en_c) begin
      csum_d = csum_q ^ bus.s_data;
      if (pk_ready_c) begin
        mem_we_d    = 1'b1;
        mem_addr_d  = ADDR_W'(words_loaded);
        mem_wdata_d = pk_word_c;
        words_d     = words_loaded + CNT_W'(1);
      end
    end

    if ((state_d == DONE) && (state_q == CSUM)) begin
      core_hold_d = 1'b0;
      load_done_d = 1'b1;
    end
    if ((state_d == ERR) && (state_q != ERR)) begin
      core_hold_d = 1'b1;
      load_err_d  = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_ready_q    <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      core_hold    <= HOLD_AT_RESET;
      load_done    <= 1'b0;
      load_err     <= 1'b0;
      words_loaded <= '0;
      len_q        <= '0;
      csum_q       <= '0;
    end else begin
      s_ready_q    <= s_ready_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      core_hold    <= core_hold_d;
      load_done    <= load_done_d;
      load_err     <= load_err_d;
      words_loaded <= words_d;
      len_q        <= len_d;
      csum_q       <= csum_d;
    end
  end

  assign bus.s_ready   = s_ready_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: expected port-B writes are queued as
// bytes are sent and compared (address, data, cycle) when mem_we fires.
module tb_imem_loader;

  localparam int unsigned ADDR_W = 4;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    int          cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic core_hold, load_done, load_err;
  logic [ADDR_W:0] words_loaded;

  imem_loader_if #(.ADDR_W(ADDR_W)) bus ();

  imem_loader #(.ADDR_W(ADDR_W), .HOLD_AT_RESET(1'b1)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .bus          (bus),
    .core_hold    (core_hold),
    .load_done    (load_done),
    .load_err     (load_err),
    .words_loaded (words_loaded)
  );

  always #5 clk = ~clk;

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   writes = 0;
  exp_t exp_q[$];
  logic [31:0] img [16];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard: every write must match the oldest queued expectation.
  always @(negedge clk) begin
    if (rst_n && bus.mem_we) begin
      exp_t e;
      writes <= writes + 1;
      if (exp_q.size() == 0) begin
        check("unexpected_write", 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        check("waddr", 32'(bus.mem_addr), e.addr);
        check("wdata", bus.mem_wdata, e.data);
        check("wcycle", 32'(cyc), 32'(e.cyc));
      end
    end
  end

  task automatic send_byte(input logic [7:0] b, input int gap, output int acc_cyc);
    bit got = 1'b0;
    acc_cyc = 0;
    bus.s_valid = 1'b0;
    repeat (gap) begin @(posedge clk); #1; end
    bus.s_valid = 1'b1;
    bus.s_data  = b;
    for (int t = 0; t < 20 && !got; t++) begin
      @(negedge clk);
      if (bus.s_ready) begin
        got = 1'b1;
        acc_cyc = cyc;
      end
    end
    if (!got) check("ready_timeout", 32'd0, 32'd1);
    else begin @(posedge clk); #1; end
    bus.s_valid = 1'b0;
  endtask

  task automatic send_word(input int idx, input logic [31:0] w, input int max_gap,
                           inout logic [7:0] cs);
    int ac = 0;
    logic [7:0] b;
    for (int k = 0; k < 4; k++) begin
      b = w[8*k +: 8];
      send_byte(b, int'($urandom_range(0, max_gap)), ac);
      cs = cs ^ b;
    end
    exp_q.push_back('{addr: 32'(idx), data: w, cyc: ac + 1});
  endtask

  // Start is raised together with the first byte, which must not be taken early.
  task automatic begin_frame(input logic [31:0] n);
    int ac;
    bus.s_valid = 1'b1;
    bus.s_data  = n[7:0];
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check("ready_after_start", 32'(bus.s_ready), 32'd1);
    for (int k = 0; k < 4; k++) send_byte(n[8*k +: 8], 0, ac);
  endtask

  task automatic send_frame(input logic [31:0] n, input int nwords, input bit bad,
                            input int max_gap, input bit send_cs);
    logic [7:0] cs = 8'h00;
    int ac;
    begin_frame(n);
    for (int i = 0; i < nwords; i++) send_word(i, img[i], max_gap, cs);
    if (send_cs) send_byte(bad ? (cs ^ 8'h01) : cs, 0, ac);
    repeat (3) @(negedge clk);
  endtask

  task automatic expect_end(input string tag, input bit done, input bit err,
                            input int words, input int w0, input int nwr);
    check({tag, ".done"}, 32'(load_done), 32'(done));
    check({tag, ".err"}, 32'(load_err), 32'(err));
    check({tag, ".hold"}, 32'(core_hold), 32'(!done));
    check({tag, ".words"}, 32'(words_loaded), 32'(words));
    check({tag, ".ready"}, 32'(bus.s_ready), 32'd0);
    check({tag, ".we"}, 32'(bus.mem_we), 32'd0);
    check({tag, ".nwrites"}, 32'(writes - w0), 32'(nwr));
    check({tag, ".pending"}, 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    int w0;
    int ac;
    logic [7:0] cs;
    bus.s_valid = 1'b0;
    bus.s_data  = 8'h00;

    // Reset and idle without start.
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (10) @(negedge clk);
    expect_end("idle", 1'b0, 1'b0, 0, 0, 0);

    // Two-word image, good checksum.
    img[0] = 32'h0000_0013;
    img[1] = 32'h0010_0093;
    w0 = writes;
    send_frame(32'd2, 2, 1'b0, 0, 1'b1);
    expect_end("good2", 1'b1, 1'b0, 2, w0, 2);

    // Same image, corrupted checksum.
    w0 = writes;
    send_frame(32'd2, 2, 1'b1, 0, 1'b1);
    expect_end("badcs", 1'b0, 1'b1, 2, w0, 2);

    // Length beyond capacity.
    w0 = writes;
    send_frame(32'd17, 0, 1'b0, 0, 1'b0);
    expect_end("toolong", 1'b0, 1'b1, 0, w0, 0);

    // Empty image.
    w0 = writes;
    send_frame(32'd0, 0, 1'b0, 0, 1'b1);
    expect_end("empty", 1'b1, 1'b0, 0, w0, 0);

    // Full-capacity image with random valid gaps.
    for (int i = 0; i < 16; i++) img[i] = $urandom;
    w0 = writes;
    send_frame(32'd16, 16, 1'b0, 2, 1'b1);
    expect_end("full", 1'b1, 1'b0, 16, w0, 16);

    // Reset in the middle of the payload.
    img[0] = $urandom;
    cs = 8'h00;
    begin_frame(32'd3);
    send_word(0, img[0], 0, cs);
    send_byte(8'hA5, 0, ac);
    #1 rst_n = 1'b0;
    #1;
    check("rst.hold", 32'(core_hold), 32'd1);
    check("rst.ready", 32'(bus.s_ready), 32'd0);
    check("rst.words", 32'(words_loaded), 32'd0);
    check("rst.done", 32'(load_done), 32'd0);
    exp_q.delete();
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Clean reload after the reset.
    for (int i = 0; i < 5; i++) img[i] = $urandom;
    w0 = writes;
    send_frame(32'd5, 5, 1'b0, 1, 1'b1);
    expect_end("reload", 1'b1, 1'b0, 5, w0, 5);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
